// File: rtl/vgachargen_apb_slave.sv
// vgachargen_apb_slave: APB3 completer giving port-A access to the character map, colour map and glyph table BRAMs.
module vgachargen_apb_slave #(
    parameter int CH_MAP_ADDR_WIDTH  = 12,
    parameter int CH_MAP_DATA_WIDTH  = 8,
    parameter int CH_MAP_DEPTH       = 2400,
    parameter int COL_MAP_ADDR_WIDTH = 12,
    parameter int COL_MAP_DATA_WIDTH = 8,
    parameter int CH_T_ADDR_WIDTH    = 7,
    parameter int CH_T_DATA_WIDTH    = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pwrite_i,
    input  logic [31:0]                   paddr_i,
    input  logic [31:0]                   pwdata_i,
    output logic [31:0]                   prdata_o,
    output logic                          pready_o,
    output logic                          pslverr_o,
    output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
    output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
    output logic                          ch_map_wen_o,
    input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
    output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
    output logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_o,
    output logic                          col_map_wen_o,
    input  logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_i,
    output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
    output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
    output logic                          ch_t_rw_wen_o,
    input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);
    typedef enum logic [2:0] {IDLE, ERR, MAP_WR, RD_ADDR, RD_DATA, RMW_RD, RMW_MERGE, RMW_WR} state_e;
    state_e state_q, state_d;
    logic [1:0]                    region_q, region_d;
    logic [1:0]                    lane_q, lane_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_q, ch_map_addr_d;
    logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_q, ch_map_data_d;
    logic                          ch_map_wen_q, ch_map_wen_d;
    logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_q, col_map_addr_d;
    logic [COL_MAP_DATA_WIDTH-1:0] col_map_data_q, col_map_data_d;
    logic                          col_map_wen_q, col_map_wen_d;
    logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_q, ch_t_rw_addr_d;
    logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_q, ch_t_rw_data_d;
    logic                          ch_t_rw_wen_q, ch_t_rw_wen_d;
    logic                          access, in_ch, in_col, in_gl, ch_ok, dec_err, start;
    logic [11:0]                   idx;
    always_comb begin
        access  = psel_i & penable_i;
        idx     = paddr_i[13:2];
        in_ch   = paddr_i[15:14] == 2'b00;
        in_col  = paddr_i[15:14] == 2'b01;
        in_gl   = paddr_i[15:11] == 5'b10000;
        ch_ok   = 32'(idx) < 32'(CH_MAP_DEPTH);
        dec_err = (|paddr_i[31:16]) | (|paddr_i[1:0]) | (in_ch & ~ch_ok) | ~(in_ch | in_col | in_gl);
        start   = (state_q == IDLE) & access & ~dec_err;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            region_q       <= '0;
            lane_q         <= '0;
            wdata_q        <= '0;
            ch_map_addr_q  <= '0;
            ch_map_data_q  <= '0;
            ch_map_wen_q   <= 1'b0;
            col_map_addr_q <= '0;
            col_map_data_q <= '0;
            col_map_wen_q  <= 1'b0;
            ch_t_rw_addr_q <= '0;
            ch_t_rw_data_q <= '0;
            ch_t_rw_wen_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            region_q       <= region_d;
            lane_q         <= lane_d;
            wdata_q        <= wdata_d;
            ch_map_addr_q  <= ch_map_addr_d;
            ch_map_data_q  <= ch_map_data_d;
            ch_map_wen_q   <= ch_map_wen_d;
            col_map_addr_q <= col_map_addr_d;
            col_map_data_q <= col_map_data_d;
            col_map_wen_q  <= col_map_wen_d;
            ch_t_rw_addr_q <= ch_t_rw_addr_d;
            ch_t_rw_data_q <= ch_t_rw_data_d;
            ch_t_rw_wen_q  <= ch_t_rw_wen_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (access) state_d = dec_err ? ERR : ~pwrite_i ? RD_ADDR : in_gl ? RMW_RD : MAP_WR;
            RD_ADDR:   state_d = RD_DATA;
            RMW_RD:    state_d = RMW_MERGE;
            RMW_MERGE: state_d = RMW_WR;
            default:   state_d = IDLE;
        endcase
        if (state_q != IDLE && !psel_i) state_d = IDLE;
    end
    // Memory-side registers: loaded at decode, glyph lane merged in RMW_MERGE.
    always_comb begin
        region_d       = region_q;
        lane_d         = lane_q;
        wdata_d        = wdata_q;
        ch_map_addr_d  = ch_map_addr_q;
        ch_map_data_d  = ch_map_data_q;
        ch_map_wen_d   = 1'b0;
        col_map_addr_d = col_map_addr_q;
        col_map_data_d = col_map_data_q;
        col_map_wen_d  = 1'b0;
        ch_t_rw_addr_d = ch_t_rw_addr_q;
        ch_t_rw_data_d = ch_t_rw_data_q;
        ch_t_rw_wen_d  = 1'b0;
        if (start) begin
            region_d = in_gl ? 2'd2 : in_col ? 2'd1 : 2'd0;
            lane_d   = paddr_i[3:2];
            wdata_d  = pwdata_i;
            if (in_ch) begin
                ch_map_addr_d = CH_MAP_ADDR_WIDTH'(idx);
                ch_map_data_d = pwrite_i ? CH_MAP_DATA_WIDTH'(pwdata_i[7:0]) : ch_map_data_q;
                ch_map_wen_d  = pwrite_i;
            end
            if (in_col) begin
                col_map_addr_d = COL_MAP_ADDR_WIDTH'(idx);
                col_map_data_d = pwrite_i ? COL_MAP_DATA_WIDTH'(pwdata_i[7:0]) : col_map_data_q;
                col_map_wen_d  = pwrite_i;
            end
            if (in_gl) ch_t_rw_addr_d = CH_T_ADDR_WIDTH'(paddr_i[10:4]);
        end
        if (state_q == RMW_MERGE && psel_i) begin
            ch_t_rw_data_d                         = ch_t_rw_data_i;
            ch_t_rw_data_d[{lane_q, 5'd0} +: 32]   = wdata_q;
            ch_t_rw_wen_d                          = 1'b1;
        end
    end
    always_comb begin
        pready_o  = state_q inside {ERR, MAP_WR, RD_DATA, RMW_WR};
        pslverr_o = state_q == ERR;
        prdata_o  = '0;
        if (state_q == RD_DATA)
            prdata_o = region_q == 2'd2 ? ch_t_rw_data_i[{lane_q, 5'd0} +: 32] :
                       region_q == 2'd1 ? 32'(col_map_data_i) : 32'(ch_map_data_i);
    end
    assign ch_map_addr_o  = ch_map_addr_q;
    assign ch_map_data_o  = ch_map_data_q;
    assign ch_map_wen_o   = ch_map_wen_q;
    assign col_map_addr_o = col_map_addr_q;
    assign col_map_data_o = col_map_data_q;
    assign col_map_wen_o  = col_map_wen_q;
    assign ch_t_rw_addr_o = ch_t_rw_addr_q;
    assign ch_t_rw_data_o = ch_t_rw_data_q;
    assign ch_t_rw_wen_o  = ch_t_rw_wen_q;
endmodule

// File: tb/tb_vgachargen_apb_slave.sv
// tb_vgachargen_apb_slave: scoreboard bench with behavioural port-A BRAM models.
module tb_vgachargen_apb_slave;
    logic         clk = 1'b0, rst = 1'b1;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]  paddr = '0, pwdata = '0;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o;
    logic [11:0]  ch_map_addr_o, col_map_addr_o;
    logic [7:0]   ch_map_data_o, col_map_data_o, ch_rd, col_rd;
    logic         ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o;
    logic [6:0]   ch_t_rw_addr_o;
    logic [127:0] ch_t_rw_data_o, gl_rd;
    logic [7:0]   ch_mem [4096];
    logic [7:0]   col_mem [4096];
    logic [127:0] gl_mem [128];
    int           wen_cnt = 0;
    int           n_checks = 0, n_pass = 0;

    typedef struct {
        logic [31:0]  rdata;
        logic         err;
        int           waits;
        int           port;
        logic [11:0]  addr;
        logic [127:0] wdata;
    } exp_t;
    exp_t sb[$];

    vgachargen_apb_slave dut (
        .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o), .ch_map_wen_o(ch_map_wen_o), .ch_map_data_i(ch_rd),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o), .col_map_wen_o(col_map_wen_o), .col_map_data_i(col_rd),
        .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o), .ch_t_rw_wen_o(ch_t_rw_wen_o), .ch_t_rw_data_i(gl_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ch_map_wen_o) ch_mem[ch_map_addr_o] <= ch_map_data_o;
        if (col_map_wen_o) col_mem[col_map_addr_o] <= col_map_data_o;
        if (ch_t_rw_wen_o) gl_mem[ch_t_rw_addr_o] <= ch_t_rw_data_o;
        ch_rd   <= ch_mem[ch_map_addr_o];
        col_rd  <= col_mem[col_map_addr_o];
        gl_rd   <= gl_mem[ch_t_rw_addr_o];
        wen_cnt <= wen_cnt + int'(ch_map_wen_o) + int'(col_map_wen_o) + int'(ch_t_rw_wen_o);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] rd, input logic err, input int w, input int port,
                                input logic [11:0] a, input logic [127:0] d);
        exp_t e;
        e.rdata = rd; e.err = err; e.waits = w; e.port = port; e.addr = a; e.wdata = d;
        return e;
    endfunction

    function automatic int live_wen();
        return int'(ch_map_wen_o) + int'(col_map_wen_o) + int'(ch_t_rw_wen_o);
    endfunction

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        int   start;
        bit   done;
        exp_t x;
        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1 penable = 1'b1;
        sb.push_back(e);
        start = wen_cnt;
        done  = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(posedge clk); #1;
            if (pready_o) begin
                done = 1'b1;
                x = sb.pop_front();
                check($sformatf("wait_%h", a), 128'(c), 128'(x.waits));
                check($sformatf("rdata_%h", a), 128'(prdata_o), 128'(x.rdata));
                check($sformatf("slverr_%h", a), 128'(pslverr_o), 128'(x.err));
                case (x.port)
                    1: check($sformatf("ch_wr_%h", a), {ch_map_wen_o, ch_map_addr_o, ch_map_data_o}, {1'b1, x.addr, x.wdata[7:0]});
                    2: check($sformatf("col_wr_%h", a), {col_map_wen_o, col_map_addr_o, col_map_data_o}, {1'b1, x.addr, x.wdata[7:0]});
                    3: begin
                        check($sformatf("gl_wr_%h", a), {ch_t_rw_wen_o, ch_t_rw_addr_o}, {1'b1, x.addr[6:0]});
                        check($sformatf("gl_data_%h", a), ch_t_rw_data_o, x.wdata);
                    end
                    default: check($sformatf("no_wen_%h", a), 128'(wen_cnt - start + live_wen()), 128'(0));
                endcase
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            check($sformatf("timeout_%h", a), 128'(0), 128'(1));
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_apb"}, {prdata_o, pready_o, pslverr_o, ch_map_addr_o, ch_map_data_o, ch_map_wen_o,
                              col_map_addr_o, col_map_data_o, col_map_wen_o}, 128'(0));
        check({tag, "_gl"}, ch_t_rw_data_o, 128'(0));
        check({tag, "_gl_ctl"}, {ch_t_rw_addr_o, ch_t_rw_wen_o}, 128'(0));
    endtask

    task automatic start_glyph_write(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd;
        @(posedge clk); #1 penable = 1'b1;
    endtask

    initial begin
        int          start, rdy;
        logic [31:0] err_addr [4];
        for (int i = 0; i < 4096; i++) begin ch_mem[i] = '0; col_mem[i] = '0; end
        for (int i = 0; i < 128; i++) gl_mem[i] = '0;
        gl_mem[5] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        err_addr[0] = 32'h0000_2580; err_addr[1] = 32'h0000_8800;
        err_addr[2] = 32'h0001_0000; err_addr[3] = 32'h0000_0002;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        apb(1, 32'h0000_0010, 32'h0000_0041, mk(0, 0, 1, 1, 12'd4, 128'h41));
        apb(0, 32'h0000_0010, 32'h0, mk(32'h41, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_4000, 32'hFFFF_FF2C, mk(0, 0, 1, 2, 12'd0, 128'h2C));
        apb(0, 32'h0000_4000, 32'h0, mk(32'h2C, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_8058, 32'h1234_5678, mk(0, 0, 3, 3, 12'd5, 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA));
        apb(0, 32'h0000_8058, 32'h0, mk(32'h1234_5678, 0, 2, 0, 0, 0));
        apb(0, 32'h0000_8050, 32'h0, mk(32'hAAAA_AAAA, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_257C, 32'h0000_017E, mk(0, 0, 1, 1, 12'd2399, 128'h7E));
        apb(0, 32'h0000_257C, 32'h0, mk(32'h7E, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_7FFC, 32'h0000_00A5, mk(0, 0, 1, 2, 12'd4095, 128'hA5));
        apb(0, 32'h0000_7FFC, 32'h0, mk(32'hA5, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_87FC, 32'hCAFE_F00D, mk(0, 0, 3, 3, 12'd127, {32'hCAFE_F00D, 96'h0}));
        apb(0, 32'h0000_87FC, 32'h0, mk(32'hCAFE_F00D, 0, 2, 0, 0, 0));
        foreach (err_addr[i]) apb(1, err_addr[i], 32'hFFFF_FFFF, mk(0, 1, 1, 0, 0, 0));
        apb(0, 32'h0000_8800, 32'h0, mk(0, 1, 1, 0, 0, 0));
        go_idle();

        start_glyph_write(32'h0000_8050, 32'hDEAD_BEEF);
        start = wen_cnt;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 check_all_zero("mid_rst");
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("mid_rst_no_wen", 128'(wen_cnt - start + live_wen()), 128'(0));
        apb(0, 32'h0000_8050, 32'h0, mk(32'hAAAA_AAAA, 0, 2, 0, 0, 0));
        go_idle();

        start_glyph_write(32'h0000_8054, 32'h0000_0055);
        start = wen_cnt;
        rdy   = 0;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 rdy += int'(pready_o);
        end
        check("drop_no_wen", 128'(wen_cnt - start + live_wen()), 128'(0));
        check("drop_no_ready", 128'(rdy), 128'(0));
        apb(1, 32'h0000_0020, 32'h0000_0099, mk(0, 0, 1, 1, 12'd8, 128'h99));
        apb(0, 32'h0000_0020, 32'h0, mk(32'h99, 0, 2, 0, 0, 0));
        apb(0, 32'h0000_8054, 32'h0, mk(32'hBBBB_BBBB, 0, 2, 0, 0, 0));
        apb(1, 32'h0000_8054, 32'h0000_0077, mk(0, 0, 3, 3, 12'd5, 128'hDDDDDDDD_12345678_00000077_AAAAAAAA));
        apb(0, 32'h0000_8054, 32'h0, mk(32'h77, 0, 2, 0, 0, 0));
        apb(0, 32'h0000_0010, 32'h0, mk(32'h41, 0, 2, 0, 0, 0));
        go_idle();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
